// File: rtl/seq_detect_arbiter_if.sv
// Producer/consumer bundle for seq_detect_arbiter: per-requester symbol streams in,
// registered grant and per-session result out.
interface seq_detect_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2,
    parameter int unsigned CW   = 5
);
    logic [NREQ-1:0]   req;
    logic [2*NREQ-1:0] sym;
    logic [NREQ-1:0]   sym_valid;
    logic [NREQ-1:0]   sym_last;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              done;
    logic              hit;
    logic              aborted;
    logic [IDW-1:0]    done_id;
    logic [CW-1:0]     sym_cnt;

    modport master (
        output req, sym, sym_valid, sym_last,
        input  gnt, busy, done, hit, aborted, done_id, sym_cnt
    );

    modport slave (
        input  req, sym, sym_valid, sym_last,
        output gnt, busy, done, hit, aborted, done_id, sym_cnt
    );
endinterface

// File: rtl/seq_detect_arbiter.sv
// Round-robin shared 01,10,11 sticky sequence detector: one session per grant,
// one result strobe per session.
module seq_detect_arbiter #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned IDW    = 2,
    parameter int unsigned MAXLEN = 16,
    parameter int unsigned CW     = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seq_detect_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, GRANT, RUN, REPORT} state_t;
    typedef enum logic [1:0] {D0, D1, D2, D3} det_t;

    state_t          state, state_n;
    det_t            det, det_n;
    logic [IDW-1:0]  g, g_n;
    logic [IDW-1:0]  ptr, ptr_n;
    logic [CW-1:0]   cnt, cnt_n, cnt_inc;
    logic            ab, ab_n;
    logic [NREQ-1:0] gnt, gnt_n;

    logic [1:0]      sym_g;
    logic            valid_g, last_g, req_g;
    logic            found;
    logic [IDW-1:0]  pick;

    function automatic det_t det_step(input det_t d, input logic [1:0] s);
        det_t r;
        r = D0;
        case (d)
            D0: r = (s == 2'b01) ? D1 : D0;
            D1: r = (s == 2'b01) ? D1 : (s == 2'b10) ? D2 : D0;
            D2: r = (s == 2'b11) ? D3 : (s == 2'b01) ? D1 : D0;
            D3: r = D3;
            default: r = D0;
        endcase
        return r;
    endfunction

    // Granted requester's inputs
    always_comb begin
        sym_g   = '0;
        valid_g = 1'b0;
        last_g  = 1'b0;
        req_g   = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (32'(g) == i) begin
                sym_g   = bus.sym[2*i +: 2];
                valid_g = bus.sym_valid[i];
                last_g  = bus.sym_last[i];
                req_g   = bus.req[i];
            end
        end
    end

    // Round robin: first pass covers requesters above ptr, second pass wraps to 0
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && bus.req[i] && i > 32'(ptr)) begin
                found = 1'b1;
                pick  = IDW'(i);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && bus.req[i]) begin
                found = 1'b1;
                pick  = IDW'(i);
            end
        end
    end

    assign cnt_inc = cnt + 1'b1;

    always_comb begin
        state_n = state;
        det_n   = det;
        cnt_n   = cnt;
        g_n     = g;
        ptr_n   = ptr;
        ab_n    = ab;
        gnt_n   = gnt;
        case (state)
            IDLE: begin
                if (found) begin
                    g_n     = pick;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                det_n = D0;
                cnt_n = '0;
                ab_n  = 1'b0;
                for (int unsigned i = 0; i < NREQ; i++)
                    gnt_n[i] = (32'(g) == i);
                state_n = RUN;
            end
            RUN: begin
                if (!req_g) begin
                    ab_n    = 1'b1;
                    gnt_n   = '0;
                    state_n = REPORT;
                end else if (valid_g) begin
                    det_n = det_step(det, sym_g);
                    cnt_n = cnt_inc;
                    if (last_g || cnt_inc == CW'(MAXLEN)) begin
                        gnt_n   = '0;
                        state_n = REPORT;
                    end
                end
            end
            REPORT: begin
                ptr_n   = g;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            det   <= D0;
            cnt   <= '0;
            g     <= '0;
            ptr   <= IDW'(NREQ - 1);
            ab    <= 1'b0;
            gnt   <= '0;
        end else begin
            state <= state_n;
            det   <= det_n;
            cnt   <= cnt_n;
            g     <= g_n;
            ptr   <= ptr_n;
            ab    <= ab_n;
            gnt   <= gnt_n;
        end
    end

    // Result fields are forced to 0 outside the report cycle
    assign bus.gnt     = gnt;
    assign bus.busy    = (state == GRANT) || (state == RUN);
    assign bus.done    = (state == REPORT);
    assign bus.hit     = (state == REPORT) && (det == D3) && !ab;
    assign bus.aborted = (state == REPORT) && ab;
    assign bus.done_id = (state == REPORT) ? g : '0;
    assign bus.sym_cnt = (state == REPORT) ? cnt : '0;
endmodule

// File: tb/tb_seq_detect_arbiter.sv
// Directed bench for seq_detect_arbiter: latency, detection, round robin, abort,
// length limit and mid-session reset.
module tb_seq_detect_arbiter;
    localparam int unsigned NREQ   = 4;
    localparam int unsigned IDW    = 2;
    localparam int unsigned MAXLEN = 16;
    localparam int unsigned CW     = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_detect_arbiter_if #(.NREQ(NREQ), .IDW(IDW), .CW(CW)) bus ();

    seq_detect_arbiter #(.NREQ(NREQ), .IDW(IDW), .MAXLEN(MAXLEN), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Requester id raises req from IDLE; grant must appear two cycles later
    task automatic start(input int id, input string tag);
        bus.req[id] = 1'b1;
        tick();
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        chk({tag, "_gnt_early"}, 32'(bus.gnt), 32'd0);
        tick();
        chk({tag, "_gnt"}, 32'(bus.gnt), 32'd1 << id);
    endtask

    task automatic send(input int id, input logic [1:0] s, input logic last);
        bus.sym[2*id +: 2]  = s;
        bus.sym_valid[id]   = 1'b1;
        bus.sym_last[id]    = last;
        tick();
        bus.sym_valid[id]   = 1'b0;
        bus.sym_last[id]    = 1'b0;
    endtask

    task automatic report(input string tag, input int id, input logic h, input logic ab,
                          input int cnt, input bit drop);
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_hit"}, 32'(bus.hit), 32'(h));
        chk({tag, "_aborted"}, 32'(bus.aborted), 32'(ab));
        chk({tag, "_id"}, 32'(bus.done_id), 32'(id));
        chk({tag, "_cnt"}, 32'(bus.sym_cnt), 32'(cnt));
        chk({tag, "_gnt_off"}, 32'(bus.gnt), 32'd0);
        if (drop) bus.req = '0;
        tick();
        chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        bus.req       = '0;
        bus.sym       = '0;
        bus.sym_valid = '0;
        bus.sym_last  = '0;
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_cnt", 32'(bus.sym_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic hit on requester 0
        start(0, "t1");
        send(0, 2'b01, 1'b0);
        send(0, 2'b10, 1'b0);
        send(0, 2'b11, 1'b1);
        report("t1", 0, 1'b1, 1'b0, 3, 1'b1);

        // Broken pattern, then sticky hit, on requester 2
        start(2, "t2a");
        send(2, 2'b01, 1'b0);
        send(2, 2'b01, 1'b0);
        send(2, 2'b10, 1'b0);
        send(2, 2'b00, 1'b0);
        send(2, 2'b11, 1'b1);
        report("t2a", 2, 1'b0, 1'b0, 5, 1'b1);
        start(2, "t2b");
        send(2, 2'b01, 1'b0);
        send(2, 2'b10, 1'b0);
        send(2, 2'b11, 1'b0);
        send(2, 2'b00, 1'b0);
        send(2, 2'b00, 1'b1);
        report("t2b", 2, 1'b1, 1'b0, 5, 1'b1);

        // Move the pointer to 3 so the held-request order starts at 0
        start(3, "t3pre");
        send(3, 2'b00, 1'b1);
        report("t3pre", 3, 1'b0, 1'b0, 1, 1'b1);

        bus.req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            start(k % 4, "t3rr");
            if (k == 7) bus.req = 4'b1010;
            send(k % 4, 2'b01, 1'b1);
            report("t3rr", k % 4, 1'b0, 1'b0, 1, 1'b0);
        end
        start(1, "t3skip");
        send(1, 2'b00, 1'b1);
        report("t3skip", 1, 1'b0, 1'b0, 1, 1'b1);

        // Abort on requester 1: symbol presented with the drop is not counted
        start(1, "t4");
        send(1, 2'b01, 1'b0);
        send(1, 2'b10, 1'b0);
        bus.req[1]       = 1'b0;
        bus.sym[3:2]     = 2'b11;
        bus.sym_valid[1] = 1'b1;
        tick();
        bus.sym_valid[1] = 1'b0;
        report("t4", 1, 1'b0, 1'b1, 2, 1'b1);

        // Length limit on requester 0
        start(0, "t5");
        for (int k = 0; k < 15; k++) send(0, 2'b00, 1'b0);
        chk("t5_no_early_done", 32'(bus.done), 32'd0);
        send(0, 2'b00, 1'b0);
        bus.sym_valid[0] = 1'b1;
        report("t5", 0, 1'b0, 1'b0, 16, 1'b1);
        chk("t5_idle", 32'(bus.busy), 32'd0);
        bus.sym_valid[0] = 1'b0;

        // Reset mid-session discards it
        start(2, "t6");
        send(2, 2'b01, 1'b0);
        send(2, 2'b10, 1'b0);
        rst_n   = 1'b0;
        bus.req = '0;
        tick();
        chk("t6_gnt", 32'(bus.gnt), 32'd0);
        chk("t6_done", 32'(bus.done), 32'd0);
        chk("t6_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("t6_done2", 32'(bus.done), 32'd0);
        start(0, "t6new");
        send(0, 2'b11, 1'b1);
        report("t6new", 0, 1'b0, 1'b0, 1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_detect_arbiter.md
Name: seq_detect_arbiter

Overview:
- Shares one 2-bit sequence detector (pattern 01,10,11; sticky once matched) among NREQ requesters.
- Grants the detector round-robin, one session at a time, and streams the granted requester's symbols into it.
- Reports one result per session: hit, abort, requester id and symbol count.
- Sits between the symbol producers and the result consumer; owns the detector state.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester id width; must satisfy 2^IDW >= NREQ.
- MAXLEN, 16, maximum symbols per session before forced termination.
- CW, 5, symbol counter width; must hold MAXLEN.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- req  in  NREQ  session request per requester; held for the whole session.
- sym  in  2*NREQ  symbol of requester i at bits [2i+1:2i].
- sym_valid  in  NREQ  symbol valid per requester.
- sym_last  in  NREQ  marks the final symbol of a session; qualified by sym_valid.
- gnt  out  NREQ  one-hot grant, registered.
- busy  out  1  high in GRANT and RUN.
- done  out  1  one-cycle result strobe.
- hit  out  1  session matched the pattern; valid when done=1.
- aborted  out  1  session ended by req withdrawal; valid when done=1.
- done_id  out  IDW  id of the reported requester; valid when done=1.
- sym_cnt  out  CW  symbols consumed in the reported session; valid when done=1.

Behaviour:
- Reset (rst_n=0 at posedge):
  - All outputs 0 and state IDLE.
  - Detector in D0, counter 0.
  - RR pointer set so requester 0 has highest priority.
  - Reset mid-session discards the session with no done strobe.
- Controller states:
  - IDLE: if any req, pick the first asserted req at or after (last_granted+1) mod NREQ, then go to GRANT. If no req, stay in IDLE.
  - GRANT: gnt one-hot asserted; detector cleared to D0; counter cleared. Always go to RUN.
  - RUN: each cycle with sym_valid[g]=1, consume sym[g]: advance the detector and increment the counter. Inputs of non-granted requesters are ignored.
  - REPORT: done=1 for exactly one cycle with hit, aborted, done_id and sym_cnt; gnt=0; RR pointer set to g. Always go to IDLE.
- Latency: req seen in IDLE at cycle t gives gnt=1 at t+2. The first symbol can be consumed at t+2. done follows the final symbol by exactly 1 cycle.
- Detector transitions (one per consumed symbol):
  - D0: 01 goes to D1; any other symbol stays in D0.
  - D1: 01 stays in D1; 10 goes to D2; any other symbol goes to D0.
  - D2: 11 goes to D3; 01 goes to D1; any other symbol goes to D0.
  - D3: stays in D3 for every symbol (sticky).
  - hit is computed from the state after the final symbol has been applied.
- Session end conditions, checked in RUN with priority abort > last > length:
  - req[g]=0: go to REPORT with aborted=1 and hit=0. A symbol valid in the same cycle is not consumed.
  - sym_valid[g]&sym_last[g]: consume the symbol, then go to REPORT with aborted=0.
  - Counter reaches MAXLEN after consuming a symbol: go to REPORT with aborted=0. Later symbols are not consumed.
- No early termination on hit; the session continues until one of the end conditions.
- The sym_last/MAXLEN end checks apply only in RUN. The requester must not present sym_valid to this block before gnt=1.
- sym_cnt saturates at MAXLEN and never wraps.
- Requests arriving during a session wait. Pointer wrap: after requester NREQ-1, priority search restarts at requester 0.

Test Plan:
- Reset, then req0=1 streaming 01,10,11 (last on 11) -> gnt=0001 two cycles after req; done=1 one cycle after the 11; hit=1, aborted=0, done_id=0, sym_cnt=3.
- req2 streams 01,01,10,00,11 (last on 11) -> done with hit=0, sym_cnt=5. Repeat with 01,10,11,00,00 (last on final 00) -> hit=1 (sticky), sym_cnt=5.
- req=1111 held, each session one symbol with last -> grant order 0,1,2,3,0. Then hold only req1 and req3 after a grant to 3 -> next grant goes to 1.
- req1 granted, sends 01,10, then drops req with sym_valid=1 carrying 11 -> done=1, aborted=1, hit=0, sym_cnt=2.
- MAXLEN=16, req0 streams 20 symbols 00 with no last -> done after the 16th symbol, sym_cnt=16, hit=0; symbols 17 to 20 are ignored.
- rst_n=0 for one cycle mid-RUN after 01,10 -> no done; gnt=0 next cycle. A new session sending 11 alone -> hit=0.
